// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared types and constants for the sample streamer
package stream_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int HDR_LEN = 5;
  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    RD_REQ,
    RD_WAIT,
    DATA,
    CHK,
    NEXT_CH,
    TX_WAIT
  } state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SENT,
    TX_BUSY
  } tx_state_e;

  function automatic int bytes_per_sample(input int sample_w);
    return sample_w / 8;
  endfunction

endpackage

// File: rtl/stream_byte_tx.sv
// rtl/stream_byte_tx.sv - one-byte-in-flight uart_tx handshake with running XOR checksum
module stream_byte_tx
  import stream_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_acc,
  output logic       in_ready,
  output logic       byte_done,
  output logic [7:0] chk,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data
);

  tx_state_e  state_q, state_d;
  logic [7:0] chk_q, chk_d;

  assign chk = chk_q;

  always_comb begin
    in_ready  = (state_q == TX_IDLE) && !tx_busy;
    tx_start  = in_valid && in_ready;
    tx_data   = tx_start ? in_data : 8'h00;
    byte_done = (state_q == TX_BUSY) && !tx_busy;
    state_d   = state_q;
    chk_d     = chk_q;
    case (state_q)
      TX_IDLE: begin
        if (tx_start) begin
          state_d = TX_SENT;
          // Non-accumulated bytes (sync, checksum) restart the running XOR.
          chk_d   = in_acc ? (chk_q ^ in_data) : 8'h00;
        end
      end
      TX_SENT: if (tx_busy) state_d = TX_BUSY;
      TX_BUSY: if (!tx_busy) state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      chk_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      chk_q   <= chk_d;
    end
  end

endmodule

// File: rtl/sample_streamer.sv
// rtl/sample_streamer.sv - windowed multi-channel sample buffer to framed uart byte stream
module sample_streamer
  import stream_pkg::*;
#(
  parameter int         SAMPLE_W  = 16,
  parameter int         ADDR_W    = 8,
  parameter int         NUM_CH    = 4,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  localparam int        CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W:0]     count,
  input  logic                abort,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic [CH_W-1:0]     rd_ch,
  input  logic [SAMPLE_W-1:0] rd_data,
  input  logic                tx_busy,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  output logic                busy,
  output logic                done,
  output logic [7:0]          seq
);

  localparam int         BYTES     = bytes_per_sample(SAMPLE_W);
  localparam logic [7:0] LAST_BYTE = 8'(BYTES - 1);

  state_e                state_q, state_d, ret_q, ret_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [NUM_CH-1:0]     mask_q, mask_d;
  logic                  mode_q, mode_d;
  logic [ADDR_W-1:0]     base_q, base_d, addr_q, addr_d;
  logic [ADDR_W:0]       len_q, len_d, rem_q, rem_d;
  logic [2:0]            hdr_q, hdr_d;
  logic [7:0]            left_q, left_d;
  logic [SAMPLE_W-1:0]   shift_q, shift_d;
  logic [7:0]            seq_q, seq_d;
  logic                  done_q, done_d, busy_q, busy_d;

  logic                  bt_valid, bt_acc, bt_ready, bt_done;
  logic [7:0]            bt_data, chk;
  logic [ADDR_W:0]       n_in;
  logic [LEN_W-1:0]      len16;
  logic [7:0]            hdr_byte;
  logic [CH_W-1:0]       nxt_ch, first_ch, start_ch;
  logic                  nxt_found;

  assign rd_addr = addr_q;
  assign rd_ch   = ch_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign seq     = seq_q;
  assign len16   = LEN_W'(len_q);
  assign n_in    = (count == '0) ? {1'b1, {ADDR_W{1'b0}}} : count;

  stream_byte_tx u_byte_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bt_valid),
    .in_data  (bt_data),
    .in_acc   (bt_acc),
    .in_ready (bt_ready),
    .byte_done(bt_done),
    .chk      (chk),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data)
  );

  // Downward scans so the lowest qualifying channel wins.
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = '0;
    first_ch  = '0;
    start_ch  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i]) first_ch = CH_W'(i);
      if (ch_mask[i]) start_ch = CH_W'(i);
      if (mask_q[i] && (i > int'(ch_q))) begin
        nxt_found = 1'b1;
        nxt_ch    = CH_W'(i);
      end
    end
  end

  always_comb begin
    case (hdr_q)
      3'd0:    hdr_byte = SYNC_BYTE;
      3'd1:    hdr_byte = 8'(ch_q);
      3'd2:    hdr_byte = seq_q;
      3'd3:    hdr_byte = len16[15:8];
      default: hdr_byte = len16[7:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    ch_d     = ch_q;
    mask_d   = mask_q;
    mode_d   = mode_q;
    base_d   = base_q;
    addr_d   = addr_q;
    len_d    = len_q;
    rem_d    = rem_q;
    hdr_d    = hdr_q;
    left_d   = left_q;
    shift_d  = shift_q;
    seq_d    = seq_q;
    done_d   = 1'b0;
    bt_valid = 1'b0;
    bt_data  = 8'h00;
    bt_acc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          mode_d = mode;
          mask_d = ch_mask;
          base_d = start_addr;
          len_d  = n_in;
          if (ch_mask == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = HDR;
            ch_d    = start_ch;
            hdr_d   = 3'd0;
            addr_d  = start_addr;
            rem_d   = n_in;
          end
        end
      end
      HDR: begin
        bt_valid = 1'b1;
        bt_data  = hdr_byte;
        bt_acc   = (hdr_q != 3'd0);
        if (bt_ready) begin
          state_d = TX_WAIT;
          hdr_d   = hdr_q + 3'd1;
          ret_d   = (hdr_q == 3'(HDR_LEN - 1)) ? RD_REQ : HDR;
        end
      end
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: begin
        shift_d = rd_data;
        left_d  = LAST_BYTE;
        addr_d  = addr_q + 1'b1;
        state_d = DATA;
      end
      DATA: begin
        bt_valid = 1'b1;
        bt_data  = shift_q[SAMPLE_W-1 -: 8];
        bt_acc   = 1'b1;
        if (bt_ready) begin
          state_d = TX_WAIT;
          shift_d = shift_q << 8;
          if (left_q == 8'd0) begin
            rem_d = rem_q - 1'b1;
            ret_d = (rem_q == {{ADDR_W{1'b0}}, 1'b1}) ? CHK : RD_REQ;
          end else begin
            left_d = left_q - 8'd1;
            ret_d  = DATA;
          end
        end
      end
      CHK: begin
        bt_valid = 1'b1;
        bt_data  = chk;
        if (bt_ready) begin
          state_d = TX_WAIT;
          ret_d   = NEXT_CH;
        end
      end
      TX_WAIT: begin
        if (bt_done) begin
          if (ret_q == NEXT_CH) seq_d = seq_q + 8'd1;
          if (abort) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ret_q;
            // Raise done now so it lands one cycle after the final byte completes.
            if (ret_q == NEXT_CH && !nxt_found && !mode_q) done_d = 1'b1;
          end
        end
      end
      NEXT_CH: begin
        hdr_d  = 3'd0;
        addr_d = base_q;
        rem_d  = len_q;
        if (nxt_found) begin
          ch_d    = nxt_ch;
          state_d = HDR;
        end else if (mode_q) begin
          ch_d    = first_ch;
          state_d = HDR;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      ch_q    <= '0;
      mask_q  <= '0;
      mode_q  <= 1'b0;
      base_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      hdr_q   <= 3'd0;
      left_q  <= 8'd0;
      shift_q <= '0;
      seq_q   <= 8'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      ch_q    <= ch_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      hdr_q   <= hdr_d;
      left_q  <= left_d;
      shift_q <= shift_d;
      seq_q   <= seq_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_sample_streamer.sv
// tb/tb_sample_streamer.sv - scoreboard bench for sample_streamer with a frame-level reference model
module tb_sample_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, mode, abort;
  logic [3:0]  ch_mask;
  logic [7:0]  start_addr;
  logic [8:0]  count;
  logic [7:0]  rd_addr;
  logic [1:0]  rd_ch;
  logic [15:0] rd_data;
  logic        tx_busy, tx_start;
  logic [7:0]  tx_data;
  logic        busy, done;
  logic [7:0]  seq;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int n_sent = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] mem[4][256];
  logic [7:0]  seq_m;
  logic [7:0]  lit[14] = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h04, 8'h10, 8'h00,
                           8'h10, 8'h01, 8'h10, 8'h02, 8'h10, 8'h03, 8'h05};

  sample_streamer #(
    .SAMPLE_W (16),
    .ADDR_W   (8),
    .NUM_CH   (4),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .ch_mask   (ch_mask),
    .start_addr(start_addr),
    .count     (count),
    .abort     (abort),
    .rd_addr   (rd_addr),
    .rd_ch     (rd_ch),
    .rd_data   (rd_data),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .busy      (busy),
    .done      (done),
    .seq       (seq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_ch][rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobed byte is popped from the scoreboard and compared.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (done) done_cnt++;
        if (tx_start) begin
          n_sent++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_byte: got %02h, expected no byte", tx_data);
          end else begin
            check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  // uart_tx stand-in: busy for a random 1..4 cycles after each strobe.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_start) begin
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  task automatic push_frame(input int c, input logic [7:0] sa, input int n, input logic [7:0] sq);
    logic [7:0]  x, a, b;
    logic [15:0] s, len;
    len = 16'(n);
    b = 8'(c);
    exp_q.push_back(8'hA5);
    exp_q.push_back(b);
    exp_q.push_back(sq);
    exp_q.push_back(len[15:8]);
    exp_q.push_back(len[7:0]);
    x = b ^ sq ^ len[15:8] ^ len[7:0];
    for (int k = 0; k < n; k++) begin
      a = sa + 8'(k);
      s = mem[c][a];
      exp_q.push_back(s[15:8]);
      exp_q.push_back(s[7:0]);
      x = x ^ s[15:8] ^ s[7:0];
    end
    exp_q.push_back(x);
  endtask

  task automatic do_start(input logic m, input logic [3:0] msk, input logic [7:0] sa,
                          input logic [8:0] cnt, input logic ab);
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = ab;
    mode = m;
    ch_mask = msk;
    start_addr = sa;
    count = cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    mode = 1'($urandom);
    ch_mask = 4'($urandom);
    start_addr = 8'($urandom);
    count = 9'($urandom);
  endtask

  task automatic wait_done(input int d0, input int limit, input string tag);
    int i;
    i = 0;
    while (done_cnt == d0 && i < limit) begin
      @(negedge clk);
      i++;
    end
    if (done_cnt == d0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: no done after %0d cycles, expected done", tag, limit);
    end
  endtask

  task automatic run_core(input logic [3:0] msk, input logic [7:0] sa, input logic [8:0] cnt,
                          input string tag);
    int d0;
    d0 = done_cnt;
    do_start(1'b0, msk, sa, cnt, 1'b0);
    @(negedge clk);
    check({tag, "_busy_t1"}, 32'(busy), 32'(msk != 4'd0));
    check({tag, "_sync_t1"}, 32'(tx_start ? tx_data : 8'h00), 32'((msk != 4'd0) ? 8'hA5 : 8'h00));
    if (msk == 4'd0) check({tag, "_done_t1"}, 32'(done), 32'd1);
    wait_done(d0, 40000, tag);
    repeat (3) @(negedge clk);
    check({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_seq"}, 32'(seq), 32'(seq_m));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic run_single(input logic [3:0] msk, input logic [7:0] sa, input logic [8:0] cnt,
                            input string tag);
    int n;
    n = (cnt == 9'd0) ? 256 : int'(cnt);
    for (int c = 0; c < 4; c++) begin
      if (msk[c]) begin
        push_frame(c, sa, n, seq_m);
        seq_m = seq_m + 8'd1;
      end
    end
    run_core(msk, sa, cnt, tag);
  endtask

  task automatic wait_sent(input int target, input string tag);
    int i;
    i = 0;
    while (n_sent < target && i < 20000) begin
      @(negedge clk);
      i++;
    end
    if (n_sent < target) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: sent %0d bytes, expected %0d", tag, n_sent, target);
    end
  endtask

  initial begin
    int d0, n0, i;
    start = 1'b0;
    mode = 1'b0;
    abort = 1'b0;
    ch_mask = 4'd0;
    start_addr = 8'd0;
    count = 9'd0;
    seq_m = 8'd0;
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++)
      for (int a = 0; a < 256; a++) mem[c][a] = 16'($urandom);
    for (int k = 0; k < 4; k++) mem[1][k] = 16'h1000 + 16'(k);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_seq", 32'(seq), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_rd_ch", 32'(rd_ch), 32'd0);

    for (int k = 0; k < 14; k++) exp_q.push_back(lit[k]);
    seq_m = 8'd1;
    run_core(4'b0010, 8'h00, 9'd4, "known_frame");

    run_single(4'b0001, 8'hFE, 9'd3, "wrap");
    run_single(4'b1010, 8'($urandom), 9'd1, "two_ch");
    run_single(4'b0100, 8'($urandom), 9'd0, "full_depth");
    run_single(4'b0000, 8'h10, 9'd5, "empty_mask");

    // start together with abort in IDLE must be ignored
    d0 = done_cnt;
    n0 = n_sent;
    do_start(1'b0, 4'b0001, 8'h00, 9'd2, 1'b1);
    @(negedge clk);
    check("start_abort_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("start_abort_done", 32'(done_cnt - d0), 32'd0);
    check("start_abort_bytes", 32'(n_sent - n0), 32'd0);

    // a second start while busy must not change the stream
    push_frame(0, 8'h20, 5, seq_m);
    seq_m = seq_m + 8'd1;
    d0 = done_cnt;
    do_start(1'b0, 4'b0001, 8'h20, 9'd5, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    mode = 1'b1;
    ch_mask = 4'b1111;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(d0, 20000, "busy_start");
    repeat (3) @(negedge clk);
    check("busy_start_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("busy_start_queue_left", 32'(exp_q.size()), 32'd0);
    check("busy_start_seq", 32'(seq), 32'(seq_m));

    // continuous mode, abort during the third frame's sample bytes
    for (int f = 0; f < 3; f++) push_frame(0, 8'h40, 3, seq_m + 8'(f));
    d0 = done_cnt;
    n0 = n_sent;
    do_start(1'b1, 4'b0001, 8'h40, 9'd3, 1'b0);
    wait_sent(n0 + 31, "abort");
    abort = 1'b1;
    wait_done(d0, 20000, "abort");
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_bytes", 32'(n_sent - n0), 32'd31);
    check("abort_queue_left", 32'(exp_q.size()), 32'd5);
    check("abort_seq", 32'(seq), 32'(seq_m + 8'd2));
    check("abort_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    seq_m = seq_m + 8'd2;

    // asynchronous reset in the middle of a frame
    push_frame(2, 8'h80, 8, seq_m);
    n0 = n_sent;
    do_start(1'b0, 4'b0100, 8'h80, 9'd8, 1'b0);
    wait_sent(n0 + 7, "reset_mid");
    #3 rst_n = 1'b0;
    #1;
    check("areset_tx_start", 32'(tx_start), 32'd0);
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_seq", 32'(seq), 32'd0);
    exp_q.delete();
    seq_m = 8'd0;
    i = 0;
    while ((tx_busy || i < 3) && i < 100) begin
      @(posedge clk);
      i++;
    end
    #1 rst_n = 1'b1;
    run_single(4'b0001, 8'h05, 9'd2, "post_reset");

    for (int r = 0; r < 6; r++)
      run_single(4'($urandom_range(1, 15)), 8'($urandom), 9'($urandom_range(1, 12)), "random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
